// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between the writeback stage and the
// long-latency unit, and tracks LL destinations still pending for hazard checks.
module regfile_write_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned WAIT_W   = 3
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               WB_valid,
   input  logic [4:0]         WB_reg,
   input  logic signed [31:0] WB_data,
   output logic               WB_ready,
   input  logic               LL_valid,
   input  logic [4:0]         LL_reg,
   input  logic signed [31:0] LL_data,
   output logic               LL_ready,
   input  logic               Issue_valid,
   input  logic [4:0]         Issue_reg,
   output logic               Issue_stall,
   input  logic [4:0]         Query_reg_1,
   input  logic [4:0]         Query_reg_2,
   output logic               Pending_1,
   output logic               Pending_2,
   output logic               RegWrite,
   output logic [4:0]         Write_register,
   output logic signed [31:0] Write_Data
);

   localparam logic [WAIT_W-1:0] LP_MAX_WAIT = WAIT_W'(MAX_WAIT);

   typedef enum logic {
      PRIO_WB = 1'b0,
      PRIO_LL = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic [WAIT_W-1:0]  w_wait_nxt;
   logic               w_wb_win;
   logic               w_ll_win;
   logic               w_grant;
   logic [4:0]         w_wr_reg;
   logic signed [31:0] w_wr_data;

   logic [31:0]        r_pending;
   logic [31:0]        w_set_mask;
   logic [31:0]        w_clr_mask;
   logic               w_issue_stall;

   logic               r_regwrite;
   logic [4:0]         r_write_register;
   logic signed [31:0] r_write_data;

   // Arbiter state and LL starvation counter
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state    <= PRIO_WB;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   // Winner selection, wait counting and priority flip
   always_comb begin
      w_wb_win    = 1'b0;
      w_ll_win    = 1'b0;
      w_state_nxt = r_state;
      w_wait_nxt  = '0;
      case (r_state)
         PRIO_WB: begin
            if (WB_valid)      w_wb_win = 1'b1;
            else if (LL_valid) w_ll_win = 1'b1;
         end
         PRIO_LL: begin
            if (LL_valid)      w_ll_win = 1'b1;
            else if (WB_valid) w_wb_win = 1'b1;
         end
         default: ;
      endcase
      if (LL_valid && !w_ll_win)
         w_wait_nxt = (r_wait_cnt == LP_MAX_WAIT) ? LP_MAX_WAIT : r_wait_cnt + WAIT_W'(1);
      if (r_state == PRIO_WB && w_wait_nxt == LP_MAX_WAIT)
         w_state_nxt = PRIO_LL;
      else if (r_state == PRIO_LL && w_ll_win)
         w_state_nxt = PRIO_WB;
   end

   assign WB_ready  = w_wb_win | ~WB_valid;
   assign LL_ready  = w_ll_win;
   assign w_grant   = w_wb_win | w_ll_win;
   assign w_wr_reg  = w_ll_win ? LL_reg  : WB_reg;
   assign w_wr_data = w_ll_win ? LL_data : WB_data;

   // Pending scoreboard updates; an LL clear overrides a same-cycle issue set
   assign w_issue_stall = Issue_valid & r_pending[Issue_reg];

   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (Issue_valid && !w_issue_stall && Issue_reg != 5'd0)
         w_set_mask[Issue_reg] = 1'b1;
      if (w_ll_win)
         w_clr_mask[LL_reg] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_pending <= '0;
      else       r_pending <= (r_pending | w_set_mask) & ~w_clr_mask;
   end

   assign Issue_stall = w_issue_stall;
   assign Pending_1   = r_pending[Query_reg_1];
   assign Pending_2   = r_pending[Query_reg_2];

   // Write port stage; register 0 grants complete but never assert RegWrite
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_regwrite       <= 1'b0;
         r_write_register <= '0;
         r_write_data     <= '0;
      end else begin
         r_regwrite <= w_grant && (w_wr_reg != 5'd0);
         if (w_grant) begin
            r_write_register <= w_wr_reg;
            r_write_data     <= w_wr_data;
         end
      end
   end

   assign RegWrite       = r_regwrite;
   assign Write_register = r_write_register;
   assign Write_Data     = r_write_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected register-file writes are
// queued as stimulus is driven and matched against the write port as it fires.
module tb_regfile_write_arbiter;

   logic               CLK = 1'b0;
   logic               RESET;
   logic               WB_valid;
   logic [4:0]         WB_reg;
   logic signed [31:0] WB_data;
   logic               WB_ready;
   logic               LL_valid;
   logic [4:0]         LL_reg;
   logic signed [31:0] LL_data;
   logic               LL_ready;
   logic               Issue_valid;
   logic [4:0]         Issue_reg;
   logic               Issue_stall;
   logic [4:0]         Query_reg_1;
   logic [4:0]         Query_reg_2;
   logic               Pending_1;
   logic               Pending_2;
   logic               RegWrite;
   logic [4:0]         Write_register;
   logic signed [31:0] Write_Data;

   int          errors = 0;
   int          checks = 0;
   logic [36:0] exp_q[$];
   logic [31:0] rf[32];

   regfile_write_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
      .CLK(CLK), .RESET(RESET),
      .WB_valid(WB_valid), .WB_reg(WB_reg), .WB_data(WB_data), .WB_ready(WB_ready),
      .LL_valid(LL_valid), .LL_reg(LL_reg), .LL_data(LL_data), .LL_ready(LL_ready),
      .Issue_valid(Issue_valid), .Issue_reg(Issue_reg), .Issue_stall(Issue_stall),
      .Query_reg_1(Query_reg_1), .Query_reg_2(Query_reg_2),
      .Pending_1(Pending_1), .Pending_2(Pending_2),
      .RegWrite(RegWrite), .Write_register(Write_register), .Write_Data(Write_Data)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      WB_valid    = 1'b0;
      LL_valid    = 1'b0;
      Issue_valid = 1'b0;
   endtask

   // Register file model
   always @(posedge CLK)
      if (!RESET && RegWrite) rf[Write_register] <= Write_Data;

   // Scoreboard: every observed write must match the oldest queued expectation
   always @(negedge CLK) begin
      logic [36:0] e;
      if (!RESET && RegWrite) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL write_unexpected: observed reg=%0d data=%0h expected no write",
                   Write_register, Write_Data);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_reg",  32'(Write_register), 32'(e[36:32]));
            check("sb_data", Write_Data, e[31:0]);
         end
      end
   end

   initial begin
      int  wi;
      bit  ll_done;
      RESET = 1'b1;
      idle();
      WB_reg = '0; WB_data = '0; LL_reg = '0; LL_data = '0;
      Issue_reg = '0; Query_reg_1 = 5'd17; Query_reg_2 = 5'd3;
      tick();
      tick();
      #2;
      check("rst_regwrite", 32'(RegWrite), 32'd0);
      check("rst_wreg",     32'(Write_register), 32'd0);
      check("rst_wdata",    Write_Data, 32'd0);
      check("rst_pend1",    32'(Pending_1), 32'd0);
      tick();

      // Reset release: first WB write
      RESET = 1'b0;
      WB_valid = 1'b1; WB_reg = 5'd8; WB_data = 32'h0000_0005;
      #2;
      check("rel_wb_ready", 32'(WB_ready), 32'd1);
      check("rel_ll_ready", 32'(LL_ready), 32'd0);
      exp_q.push_back({5'd8, 32'h5});
      tick();
      idle();
      #2;
      check("rel_regwrite", 32'(RegWrite), 32'd1);
      check("rel_wreg",     32'(Write_register), 32'd8);
      check("rel_wdata",    Write_Data, 32'd5);
      tick();
      #2;
      check("rel_rf8",       rf[8], 32'd5);
      check("hold_regwrite", 32'(RegWrite), 32'd0);
      check("hold_wreg",     32'(Write_register), 32'd8);
      tick();

      // Collision: WB first, LL next cycle
      WB_valid = 1'b1; WB_reg = 5'd9;  WB_data = 32'h0000_0A0A;
      LL_valid = 1'b1; LL_reg = 5'd10; LL_data = 32'h0000_0B0B;
      #2;
      check("col_wb_ready", 32'(WB_ready), 32'd1);
      check("col_ll_ready", 32'(LL_ready), 32'd0);
      exp_q.push_back({5'd9, 32'h0A0A});
      tick();
      WB_valid = 1'b0;
      #2;
      check("col_ll_ready2", 32'(LL_ready), 32'd1);
      check("col_wreg9",     32'(Write_register), 32'd9);
      exp_q.push_back({5'd10, 32'h0B0B});
      tick();
      idle();
      #2;
      check("col_regwrite10", 32'(RegWrite), 32'd1);
      check("col_wreg10",     32'(Write_register), 32'd10);
      tick();

      // Starvation: LL forced through after MAX_WAIT losses
      wi = 0;
      ll_done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         WB_valid = 1'b1;
         WB_reg   = 5'(20 + wi);
         WB_data  = 32'h100 + 32'(wi);
         LL_valid = !ll_done;
         LL_reg   = 5'd12;
         LL_data  = 32'h0000_C0DE;
         #2;
         check($sformatf("stv_wb_ready_c%0d", c), 32'(WB_ready), 32'(c != 4));
         check($sformatf("stv_ll_ready_c%0d", c), 32'(LL_ready), 32'(c == 4));
         if (c == 5) check("stv_wreg12", 32'(Write_register), 32'd12);
         if (c == 4) begin
            exp_q.push_back({5'd12, 32'h0000_C0DE});
            ll_done = 1'b1;
         end else begin
            exp_q.push_back({5'(20 + wi), 32'h100 + 32'(wi)});
            wi++;
         end
         tick();
      end
      idle();
      tick();

      // Scoreboard: issue, query, stall on re-issue, clear after grant
      Query_reg_1 = 5'd17; Query_reg_2 = 5'd3;
      Issue_valid = 1'b1; Issue_reg = 5'd17;
      #2;
      check("sb_issue_stall0", 32'(Issue_stall), 32'd0);
      check("sb_pend1_pre",    32'(Pending_1), 32'd0);
      tick();
      Issue_valid = 1'b0;
      #2;
      check("sb_pend1_set", 32'(Pending_1), 32'd1);
      check("sb_pend2_clr", 32'(Pending_2), 32'd0);
      tick();
      Issue_valid = 1'b1; Issue_reg = 5'd17;
      #2;
      check("sb_reissue_stall", 32'(Issue_stall), 32'd1);
      tick();
      Issue_valid = 1'b0;
      #2;
      check("sb_pend1_hold", 32'(Pending_1), 32'd1);
      tick();
      LL_valid = 1'b1; LL_reg = 5'd17; LL_data = 32'hFFFF_FFF9;
      Issue_valid = 1'b1; Issue_reg = 5'd17;
      #2;
      check("sb_ll_ready17",   32'(LL_ready), 32'd1);
      check("sb_pend1_grant",  32'(Pending_1), 32'd1);
      check("sb_stall_grant",  32'(Issue_stall), 32'd1);
      exp_q.push_back({5'd17, 32'hFFFF_FFF9});
      tick();
      idle();
      #2;
      check("sb_pend1_drop", 32'(Pending_1), 32'd0);
      tick();

      // Register 0: handshake completes, no write, never pending
      LL_valid = 1'b1; LL_reg = 5'd0; LL_data = 32'h0000_DEAD;
      Issue_valid = 1'b1; Issue_reg = 5'd0;
      Query_reg_1 = 5'd0;
      #2;
      check("r0_ll_ready", 32'(LL_ready), 32'd1);
      check("r0_stall",    32'(Issue_stall), 32'd0);
      tick();
      idle();
      #2;
      check("r0_regwrite", 32'(RegWrite), 32'd0);
      check("r0_pend",     32'(Pending_1), 32'd0);
      tick();

      // Async reset with pending[17] set, PRIO_LL reached and a write in flight
      Query_reg_1 = 5'd17;
      for (int c = 0; c < 4; c++) begin
         WB_valid = 1'b1; WB_reg = 5'(21 + c); WB_data = 32'h200 + 32'(c);
         LL_valid = 1'b1; LL_reg = 5'd17; LL_data = 32'h0000_0777;
         Issue_valid = (c == 0); Issue_reg = 5'd17;
         #2;
         check($sformatf("ar_wb_ready_c%0d", c), 32'(WB_ready), 32'd1);
         if (c < 3) exp_q.push_back({5'(21 + c), 32'h200 + 32'(c)});
         tick();
      end
      Issue_valid = 1'b0;
      WB_reg = 5'd25; WB_data = 32'h0000_0204;
      check("ar_inflight",  32'(RegWrite), 32'd1);
      check("ar_pend_pre",  32'(Pending_1), 32'd1);
      check("ar_prio_ll",   32'(LL_ready), 32'd1);
      #1;
      RESET = 1'b1;
      #1;
      check("ar_regwrite", 32'(RegWrite), 32'd0);
      check("ar_pend1",    32'(Pending_1), 32'd0);
      check("ar_wreg",     32'(Write_register), 32'd0);
      tick();
      RESET = 1'b0;
      #2;
      check("ar_restart_wb", 32'(WB_ready), 32'd1);
      check("ar_restart_ll", 32'(LL_ready), 32'd0);
      exp_q.push_back({5'd25, 32'h0000_0204});
      tick();
      WB_valid = 1'b0;
      #2;
      check("ar_ll_after", 32'(LL_ready), 32'd1);
      exp_q.push_back({5'd17, 32'h0000_0777});
      tick();
      idle();
      tick();
      tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
